// File: rtl/mod2011_residue_accum.sv
// Streaming mod-MOD accumulator for per-chunk residues, one beat per cycle, frame result on last beat.
// Optional input range check and sticky error flag enabled by defining MOD2011_RANGE_CHK_EN.
module mod2011_residue_accum #(
  parameter int MOD = 2011,
  parameter int W   = 11,
  parameter int CW  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_res,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_res,
  output logic [CW-1:0] out_cnt,
  output logic          err
);

  localparam logic ACC  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam logic [W:0] MOD_X = (W+1)'(MOD);

  logic          state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          frame_err;

  logic          in_bad;
  logic [W-1:0]  r;
  logic [W:0]    s;
  logic [W-1:0]  new_acc;
  logic [CW-1:0] next_cnt;

`ifdef MOD2011_RANGE_CHK_EN
  // Out-of-range residues are folded back once and flagged for the frame.
  always_comb begin
    in_bad = ({1'b0, in_res} >= MOD_X);
    r      = in_bad ? W'({1'b0, in_res} - MOD_X) : in_res;
  end
`else
  always_comb begin
    in_bad = 1'b0;
    r      = in_res;
  end
`endif

  always_comb begin
    s        = {1'b0, acc} + {1'b0, r};
    new_acc  = W'((s >= MOD_X) ? (s - MOD_X) : s);
    next_cnt = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  end

  assign in_ready = (state == ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (in_last) begin
              out_res   <= new_acc;
              out_cnt   <= next_cnt;
              err       <= frame_err | in_bad;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              frame_err <= 1'b0;
              state     <= HOLD;
            end else begin
              acc       <= new_acc;
              cnt       <= next_cnt;
              frame_err <= frame_err | in_bad;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mod2011_residue_accum.sv
// Randomized self-checking bench for mod2011_residue_accum against a plain-arithmetic frame model.
// Build with or without MOD2011_RANGE_CHK_EN; expectations follow the same macro.
module tb_mod2011_residue_accum;
  localparam int MOD = 2011;
  localparam int W   = 11;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_res;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [CW-1:0] out_cnt;
  logic          err;

  int compared   = 0;
  int mismatched = 0;
  int frame_q[$];

  mod2011_residue_accum #(.MOD(MOD), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cnt(out_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input int max_gap, input bit send_last);
    int waited;
    for (int i = 0; i < frame_q.size(); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      in_valid = 1'b1;
      in_res   = W'(frame_q[i]);
      in_last  = send_last && (i == frame_q.size() - 1);
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        checkOutput("accept_timeout", int'(in_ready), 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last-beat accept; checks the result, stalls, then handshakes.
  task automatic collectResult(input int stall, input bit chk_res);
    int sum = 0;
    int exp_err = 0;
    int exp_cnt;
    foreach (frame_q[i]) begin
      int r;
      r = frame_q[i];
`ifdef MOD2011_RANGE_CHK_EN
      if (r >= MOD) begin
        r = r - MOD;
        exp_err = 1;
      end
`endif
      sum += r;
    end
    exp_cnt = (frame_q.size() > 31) ? 31 : frame_q.size();
    out_ready = (stall == 0);
    @(negedge clk);
    checkOutput("out_valid_latency", int'(out_valid), 1);
    checkOutput("in_ready_in_hold", int'(in_ready), 0);
    if (chk_res) checkOutput("out_res", int'(out_res), sum % MOD);
    checkOutput("out_cnt", int'(out_cnt), exp_cnt);
    checkOutput("err", int'(err), exp_err);
    for (int k = 1; k < stall; k++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", int'(out_valid), 1);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      if (chk_res) checkOutput("stall_out_res", int'(out_res), sum % MOD);
      checkOutput("stall_out_cnt", int'(out_cnt), exp_cnt);
    end
    if (stall > 0) begin
      @(negedge clk);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      if (chk_res) checkOutput("stall_out_res", int'(out_res), sum % MOD);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("out_valid_cleared", int'(out_valid), 0);
    checkOutput("in_ready_after_hs", int'(in_ready), 1);
    checkOutput("err_cleared", int'(err), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_res", int'(out_res), 0);
    checkOutput("rst_out_cnt", int'(out_cnt), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int max_in;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_res    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    frame_q = {};
    repeat (17) frame_q.push_back(2010);
    applyStimulus(0, 1'b1);
    collectResult(0, 1'b1);

    frame_q = '{1000, 1011};
    applyStimulus(0, 1'b1);
    collectResult(0, 1'b1);

    frame_q = '{5};
    applyStimulus(0, 1'b1);
    collectResult(0, 1'b1);

    frame_q = '{7, 9};
    applyStimulus(0, 1'b1);
    collectResult(3, 1'b1);

    // Longer than the counter range, so out_cnt must saturate.
    frame_q = {};
    repeat (40) frame_q.push_back(int'($urandom_range(0, MOD - 1)));
    applyStimulus(1, 1'b1);
    collectResult(1, 1'b1);

    frame_q = '{2047};
    applyStimulus(0, 1'b1);
`ifdef MOD2011_RANGE_CHK_EN
    collectResult(0, 1'b1);
    frame_q = '{100, 2040, 5};
    applyStimulus(0, 1'b1);
    collectResult(2, 1'b1);
    frame_q = '{1};
    applyStimulus(0, 1'b1);
    collectResult(0, 1'b1);
`else
    collectResult(0, 1'b0);
`endif

    frame_q = {};
    repeat (5) frame_q.push_back(int'($urandom_range(0, MOD - 1)));
    applyStimulus(0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_q = '{3, 4};
    applyStimulus(0, 1'b1);
    collectResult(0, 1'b1);

    frame_q = '{500, 600};
    applyStimulus(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef MOD2011_RANGE_CHK_EN
    max_in = 2047;
`else
    max_in = MOD - 1;
`endif
    for (int f = 0; f < 25; f++) begin
      int len;
      len = int'($urandom_range(1, 20));
      frame_q = {};
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0)
          frame_q.push_back(int'($urandom_range(MOD - 40, max_in)));
        else
          frame_q.push_back(int'($urandom_range(0, max_in)));
      end
      applyStimulus(2, 1'b1);
      collectResult(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
